// File: rtl/reg_bank_mp_if.sv
// reg_bank_mp_if: read, write, scoreboard and clear signals of the
// multi-port register bank.
interface reg_bank_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wl_en;
  logic [ADDR_W-1:0]        wl_addr;
  logic [DATA_W-1:0]        wl_data;
  logic                     priv;
  logic                     bs_en;
  logic [ADDR_W-1:0]        bs_addr;
  logic                     clr_req;
  logic                     clr_busy;
  logic [DATA_W-1:0]        dbg_out;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data,
    output wl_en, wl_addr, wl_data, priv,
    output bs_en, bs_addr, clr_req,
    input  rd_data, rd_busy, clr_busy, dbg_out
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data,
    input  wl_en, wl_addr, wl_data, priv,
    input  bs_en, bs_addr, clr_req,
    output rd_data, rd_busy, clr_busy, dbg_out
  );
endinterface

// File: rtl/reg_bank_mp.sv
// reg_bank_mp: multi-port register bank with load scoreboard and clear
// sequencer. Optional same-cycle write bypass under macro BYPASS_EN.
module reg_bank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int RSVD_REG = 15,
  parameter int DBG_REG  = 13
) (
  input logic          clk,
  input logic          rst_n,
  reg_bank_mp_if.slave bus
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] RSVD_A = ADDR_W'(RSVD_REG);
  localparam logic [ADDR_W-1:0] DBG_A  = ADDR_W'(DBG_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NREGS-1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic              idle;
  logic              clr_act;
  logic              wa_ok;
  logic              wl_ok;
  logic              bs_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= (state == CLEAR) ? idx + ADDR_W'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.clr_req) state_nxt = CLEAR;
      CLEAR: if (idx == LAST_A) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idle    = 1'b0;
    clr_act = 1'b0;
    unique case (state)
      IDLE:    idle    = 1'b1;
      CLEAR:   clr_act = 1'b1;
      default: idle    = 1'b1;
    endcase
  end

  assign bus.clr_busy = clr_act;

  // r0 never accepts a write, so it stays at its reset value of zero
  assign wa_ok = idle && bus.wa_en && (bus.wa_addr != '0) &&
                 ((bus.wa_addr != RSVD_A) || bus.priv);
  assign wl_ok = idle && bus.wl_en && (bus.wl_addr != '0) &&
                 ((bus.wl_addr != RSVD_A) || bus.priv);
  assign bs_ok = idle && bus.bs_en && (bus.bs_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else if (clr_act) begin
      regs[idx] <= '0;
      busy[idx] <= 1'b0;
    end else begin
      if (wa_ok) regs[bus.wa_addr] <= bus.wa_data;
      if (wl_ok) regs[bus.wl_addr] <= bus.wl_data;
      if (wl_ok) busy[bus.wl_addr] <= 1'b0;
      if (bs_ok) busy[bus.bs_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = bus.rd_addr[i*ADDR_W +: ADDR_W];

`ifdef BYPASS_EN
    logic hit_wl;
    logic hit_wa;

    assign hit_wl = wl_ok && (bus.wl_addr == a);
    assign hit_wa = wa_ok && (bus.wa_addr == a) && !hit_wl;

    always_comb begin
      d = regs[a];
      unique case (1'b1)
        hit_wl:  d = bus.wl_data;
        hit_wa:  d = bus.wa_data;
        default: d = regs[a];
      endcase
    end

    assign b = busy[a] & ~hit_wl;
`else
    assign d = regs[a];
    assign b = busy[a];
`endif

    assign bus.rd_data[i*DATA_W +: DATA_W] = d;
    assign bus.rd_busy[i] = b;
  end

  assign bus.dbg_out = regs[DBG_A];
endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp: directed plus random stimulus against a behavioural
// model of the register bank.
module tb_reg_bank_mp;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 2;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reg_bank_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  reg_bank_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR),
    .RSVD_REG(15), .DBG_REG(13)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_reg [N];
  logic          m_busy [N];
  int            clr_left;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit acc(logic en, logic [AW-1:0] a);
    return en && a != 0 && (a != 15 || bus.priv) && clr_left == 0;
  endfunction

  // model: architectural effect of one clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 1'b0;
      end
      clr_left = 0;
    end else if (clr_left > 0) begin
      m_reg[N-clr_left] = '0;
      m_busy[N-clr_left] = 1'b0;
      clr_left--;
    end else begin
      bit a_ok, l_ok;
      a_ok = acc(bus.wa_en, bus.wa_addr);
      l_ok = acc(bus.wl_en, bus.wl_addr);
      if (a_ok) m_reg[bus.wa_addr] = bus.wa_data;
      if (l_ok) m_reg[bus.wl_addr] = bus.wl_data;
      if (l_ok) m_busy[bus.wl_addr] = 1'b0;
      if (bus.bs_en && bus.bs_addr != 0) m_busy[bus.bs_addr] = 1'b1;
      if (bus.clr_req) clr_left = N;
    end
  end

  // compare process
  always @(negedge clk) begin
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      logic          eb;
      a = bus.rd_addr[p*AW +: AW];
      ed = m_reg[a];
      eb = m_busy[a];
`ifdef BYPASS_EN
      if (acc(bus.wl_en, bus.wl_addr) && bus.wl_addr == a) begin
        ed = bus.wl_data;
        eb = 1'b0;
      end else if (acc(bus.wa_en, bus.wa_addr) && bus.wa_addr == a) begin
        ed = bus.wa_data;
      end
`endif
      chk("rd_data", 64'(bus.rd_data[p*DW +: DW]), 64'(ed));
      chk("rd_busy", 64'(bus.rd_busy[p]), 64'(eb));
    end
    chk("clr_busy", 64'(bus.clr_busy), 64'(clr_left > 0));
    chk("dbg_out", 64'(bus.dbg_out), 64'(m_reg[13]));
  end

  task automatic idle_in();
    bus.wa_en = 0; bus.wl_en = 0; bus.bs_en = 0;
    bus.clr_req = 0; bus.priv = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(logic [AW-1:0] a);
    bus.rd_addr[AW-1:0] = a;
    #1;
  endtask

  task automatic wa(logic [AW-1:0] a, logic [DW-1:0] d, logic p);
    bus.wa_en = 1; bus.wa_addr = a; bus.wa_data = d; bus.priv = p;
  endtask

  initial begin
    int n;
    idle_in();
    bus.rd_addr = '0;
    bus.wa_addr = '0; bus.wa_data = '0;
    bus.wl_addr = '0; bus.wl_data = '0;
    bus.bs_addr = '0;
    cyc(); cyc();
    chk("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
    rst_n = 1'b1;
    cyc();
    for (int a = 0; a < N; a++) begin
      rd0(AW'(a));
      chk("rst_reg", 64'(bus.rd_data[DW-1:0]), 64'd0);
      chk("rst_busy", 64'(bus.rd_busy[0]), 64'd0);
    end
    chk("rst_dbg", 64'(bus.dbg_out), 64'd0);

    wa(5, 32'hDEADBEEF, 0);
    bus.wl_en = 1; bus.wl_addr = 5; bus.wl_data = 32'h12345678;
    cyc(); idle_in(); rd0(5);
    chk("wl_wins", 64'(bus.rd_data[DW-1:0]), 64'h12345678);

    wa(0, 32'hFFFFFFFF, 0);
    cyc(); idle_in(); rd0(0);
    chk("r0_zero", 64'(bus.rd_data[DW-1:0]), 64'd0);
    wa(15, 32'hAA, 0);
    cyc(); idle_in(); rd0(15);
    chk("rsvd_noprv", 64'(bus.rd_data[DW-1:0]), 64'd0);
    wa(15, 32'hAA, 1);
    cyc(); idle_in(); rd0(15);
    chk("rsvd_prv", 64'(bus.rd_data[DW-1:0]), 64'hAA);

    bus.bs_en = 1; bus.bs_addr = 7;
    cyc(); idle_in(); rd0(7);
    chk("busy_set", 64'(bus.rd_busy[0]), 64'd1);
    bus.wl_en = 1; bus.wl_addr = 7; bus.wl_data = 32'h55;
    #1;
`ifdef BYPASS_EN
    chk("byp_busy", 64'(bus.rd_busy[0]), 64'd0);
    chk("byp_data", 64'(bus.rd_data[DW-1:0]), 64'h55);
`else
    chk("nobyp_busy", 64'(bus.rd_busy[0]), 64'd1);
    chk("nobyp_data", 64'(bus.rd_data[DW-1:0]), 64'd0);
`endif
    cyc(); idle_in(); #1;
    chk("busy_clr", 64'(bus.rd_busy[0]), 64'd0);
    chk("r7_data", 64'(bus.rd_data[DW-1:0]), 64'h55);

    for (int a = 1; a < 15; a++) begin
      wa(AW'(a), 32'h100 + a, 0);
      bus.bs_en = 1; bus.bs_addr = AW'(a);
      cyc();
    end
    idle_in();
    bus.clr_req = 1;
    cyc(); idle_in();
    n = 0;
    while (bus.clr_busy && n < 40) begin
      n++;
      if (n == 5) wa(3, 32'h77, 1);
      cyc(); idle_in();
    end
    chk("clr_len", 64'(n), 64'd16);
    for (int a = 0; a < N; a++) begin
      rd0(AW'(a));
      chk("clr_reg", 64'(bus.rd_data[DW-1:0]), 64'd0);
      chk("clr_bsy", 64'(bus.rd_busy[0]), 64'd0);
    end

    for (int a = 8; a < 12; a++) begin
      wa(AW'(a), 32'hC0DE0000 + a, 0);
      cyc();
    end
    idle_in();
    bus.clr_req = 1;
    cyc(); idle_in();
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("rstmid_clr", 64'(bus.clr_busy), 64'd0);
    rd0(10);
    chk("rstmid_r10", 64'(bus.rd_data[DW-1:0]), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int k = 0; k < 3000; k++) begin
      bus.rd_addr = NR*AW'($urandom);
      bus.wa_en = ($urandom_range(0, 2) != 0);
      bus.wa_addr = AW'($urandom);
      bus.wa_data = $urandom;
      bus.wl_en = ($urandom_range(0, 2) == 0);
      bus.wl_addr = ($urandom_range(0, 3) == 0) ? bus.wa_addr : AW'($urandom);
      bus.wl_data = $urandom;
      bus.priv = $urandom_range(0, 1);
      bus.bs_en = ($urandom_range(0, 3) == 0);
      bus.bs_addr = AW'($urandom);
      bus.clr_req = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.rd_addr[AW-1:0] = bus.wl_addr;
        bus.rd_addr[2*AW-1:AW] = bus.wa_addr;
      end
      cyc();
    end
    idle_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised multi-port register bank for the CPU datapath: configurable data width, register count and read-port count, plus two write ports (ALU and load/store). It adds a pending-load scoreboard, optional same-cycle write bypass and a hardware clear sequencer, and keeps the hardwired-zero, write-protected kernel and debug-tap register conventions. It sits between decode (read), writeback (write) and the hazard unit (busy flags).

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 4, address width; NREGS = 2**ADDR_W
- NUM_RD, 2, number of read ports
- RSVD_REG, 15, kernel-reserved register; written only when priv=1
- DBG_REG, 13, register mirrored on dbg_out

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  per-port "operand pending" flag
- wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  ALU write port
- wl_en / wl_addr / wl_data  in  1 / ADDR_W / DATA_W  load write port; clears busy
- priv  in  1  enables writes to RSVD_REG
- bs_en / bs_addr  in  1 / ADDR_W  set the busy bit (load issued)
- clr_req  in  1  start clear sequence
- clr_busy  out  1  clear sequence in progress
- dbg_out  out  DATA_W  content of DBG_REG

## Operation
- Storage: NREGS x DATA_W registers plus NREGS busy bits. Register 0 always reads 0; writes to it are dropped, and its busy bit never sets.
- Write acceptance: a port writes on a rising edge when en=1, addr!=0, (addr!=RSVD_REG or priv=1) and FSM=IDLE.
- Both write ports hitting the same address: wl wins.
- Scoreboard: bs_en sets busy[bs_addr]; an accepted wl write clears busy[wl_addr]. If the set and the clear hit the same address in one cycle, set wins. wa writes do not touch busy bits.
- rd_busy[i] = busy[rd_addr_i], except that with BYPASS_EN it reads 0 when an accepted wl write targets rd_addr_i in the same cycle.
- Clear FSM:
  - IDLE: on clr_req, go to CLEAR with idx=0.
  - CLEAR: each cycle write 0 to reg[idx] and clear busy[idx]. RSVD_REG is also cleared, regardless of priv. idx increments each cycle.
  - Leaving CLEAR: after idx=NREGS-1, return to IDLE.
  - While in CLEAR: clr_busy=1; wa, wl and bs are ignored (dropped); clr_req is ignored.
- Reset (async, any time including mid-CLEAR): all registers 0, busy all 0, FSM IDLE, idx 0.
- Reset values of outputs: rd_data 0, rd_busy 0, clr_busy 0, dbg_out 0.

## Timing
- Reads are combinational from the addresses; there is no read latency.
- Writes and busy updates take effect at the rising edge and are visible the cycle after.
- Clear sequence: clr_busy rises the cycle after clr_req is sampled and stays high for exactly NREGS cycles. Writes are accepted again on the first cycle with clr_busy=0.
- dbg_out is combinational from reg[DBG_REG].

## Configuration
- BYPASS_EN defined: when a read address matches an accepted same-cycle write, rd_data returns that write data (wl takes priority over wa), and rd_busy is masked as described above. Register 0 and rejected writes are never forwarded.
- BYPASS_EN undefined: rd_data always returns the stored value, and rd_busy reflects the stored busy bit only. A same-cycle write is seen on the next cycle.

## Test plan
- Reset, then read every register -> all 0; rd_busy=0; dbg_out=0.
- wa writes 0xDEADBEEF to r5; wl writes 0x12345678 to r5 in the same cycle -> next cycle r5=0x12345678.
- Write r0=0xFFFFFFFF -> reads 0. Write r15=0xAA with priv=0 -> r15 stays 0. Repeat with priv=1 -> r15=0xAA.
- bs_en on r7 -> rd_busy=1 for r7. Then wl writes 0x55 to r7 -> busy clears (same cycle with BYPASS_EN, next cycle without); with BYPASS_EN rd_data=0x55 in the write cycle.
- Fill r1..r14, then pulse clr_req -> clr_busy high for 16 cycles. A wa write issued mid-sequence is dropped. Afterwards all registers and busy bits are 0.
- Assert rst_n=0 mid-CLEAR -> immediate return to IDLE, clr_busy=0, all registers 0.
